// File: rtl/mem2_stage_if.sv
// mem2_stage_if: bundle, data-response and writeback signals of mem2_stage.
interface mem2_stage_if #(parameter int LANES = 2, parameter int DW = 64);
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [LANES-1:0]   in_lane_valid;
  logic [LANES*32-1:0] in_pc;
  logic [LANES*5-1:0] in_dst;
  logic [LANES*DW-1:0] in_alu_out;
  logic [LANES*2-1:0] in_memrw;
  logic [LANES*2-1:0] in_msize;
  logic [LANES-1:0]   in_memsext;
  logic               dresp_data_ok;
  logic [DW-1:0]      dresp_data;
  logic               out_valid;
  logic               out_ready;
  logic [LANES-1:0]   out_lane_valid;
  logic [LANES*32-1:0] out_pc;
  logic [LANES*5-1:0] out_dst;
  logic [LANES*DW-1:0] out_result;
  logic [LANES-1:0]   out_exc;
  logic [LANES*5-1:0] out_exc_code;
  modport master (
    output flush, in_valid, in_lane_valid, in_pc, in_dst, in_alu_out, in_memrw, in_msize,
           in_memsext, dresp_data_ok, dresp_data, out_ready,
    input  in_ready, out_valid, out_lane_valid, out_pc, out_dst, out_result, out_exc, out_exc_code
  );
  modport slave (
    input  flush, in_valid, in_lane_valid, in_pc, in_dst, in_alu_out, in_memrw, in_msize,
           in_memsext, dresp_data_ok, dresp_data, out_ready,
    output in_ready, out_valid, out_lane_valid, out_pc, out_dst, out_result, out_exc, out_exc_code
  );
endinterface

// File: rtl/mem2_stage.sv
// mem2_stage: registered memory stage 2 with load extraction and flush-safe response tracking.
// Define MEM2_MISALIGN_EXC_EN to enable misalignment exceptions (AdEL/AdES).
module mem2_stage #(parameter int LANES = 2, parameter int DW = 64) (
  input logic clk,
  input logic reset,
  mem2_stage_if.slave bus
);
  localparam int IW = LANES > 1 ? $clog2(LANES) : 1;
  localparam int OW = $clog2(DW / 8);
  typedef enum logic [1:0] {IDLE, WAIT, FULL, DRAIN} state_t;
  state_t state, nxt;
  logic found, mis, load, go_wait, accept;
  logic [IW-1:0] idx, idx_q;
  logic [2:0] alo;
  logic [1:0] msize, msize_q;
  logic load_q, sext_q;
  logic [OW-1:0] off_q;
  logic [LANES-1:0] exc_d;
  logic [LANES*5-1:0] code_d;
  logic [DW-1:0] sh, mask, ext;
  // lowest-index valid lane with a memory op owns the single bus request
  always_comb begin
    found = 1'b0;
    idx = '0;
    for (int i = LANES - 1; i >= 0; i--)
      if (bus.in_lane_valid[i] && bus.in_memrw[2*i +: 2] != 2'b00) begin
        found = 1'b1;
        idx = IW'(i);
      end
  end
  assign alo = bus.in_alu_out[idx*DW +: 3];
  assign msize = bus.in_msize[idx*2 +: 2];
  assign load = bus.in_memrw[idx*2 +: 2] == 2'b01;
`ifdef MEM2_MISALIGN_EXC_EN
  assign mis = found && ((msize == 2'd1 && alo[0]) || (msize == 2'd2 && alo[1:0] != 2'b00) ||
                         (msize == 2'd3 && alo != 3'b000));
`else
  assign mis = 1'b0;
`endif
  assign go_wait = found && !mis;
  assign bus.in_ready = !bus.flush && (state == IDLE || (state == FULL && bus.out_ready));
  assign accept = bus.in_valid && bus.in_ready;
  assign bus.out_valid = state == FULL;
  always_comb begin
    exc_d = '0;
    code_d = '0;
    for (int i = 0; i < LANES; i++) begin
      exc_d[i] = mis && idx == IW'(i);
      code_d[5*i +: 5] = exc_d[i] ? (load ? 5'd4 : 5'd5) : 5'd0;
    end
  end
  // mask covers the access size; a shift past DW leaves all bits kept
  always_comb begin
    sh = bus.dresp_data >> {off_q, 3'b000};
    mask = ~({DW{1'b1}} << (7'd8 << msize_q));
    ext = (sext_q && |(sh & (mask ^ (mask >> 1)))) ? (sh | ~mask) : (sh & mask);
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  nxt = accept ? (go_wait ? WAIT : FULL) : IDLE;
      WAIT:  nxt = bus.flush ? (bus.dresp_data_ok ? IDLE : DRAIN) : (bus.dresp_data_ok ? FULL : WAIT);
      FULL:  nxt = bus.flush ? IDLE : !bus.out_ready ? FULL : accept ? (go_wait ? WAIT : FULL) : IDLE;
      DRAIN: nxt = bus.dresp_data_ok ? IDLE : DRAIN;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      bus.out_lane_valid <= '0;
      bus.out_pc <= '0;
      bus.out_dst <= '0;
      bus.out_result <= '0;
      bus.out_exc <= '0;
      bus.out_exc_code <= '0;
      idx_q <= '0;
      load_q <= 1'b0;
      sext_q <= 1'b0;
      msize_q <= 2'd0;
      off_q <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        bus.out_lane_valid <= bus.in_lane_valid;
        bus.out_pc <= bus.in_pc;
        bus.out_dst <= bus.in_dst;
        bus.out_result <= bus.in_alu_out;
        bus.out_exc <= exc_d;
        bus.out_exc_code <= code_d;
        idx_q <= idx;
        load_q <= found && load;
        sext_q <= bus.in_memsext[idx];
        msize_q <= msize;
        off_q <= alo[OW-1:0];
      end
      if (state == WAIT && bus.dresp_data_ok && !bus.flush && load_q)
        bus.out_result[idx_q*DW +: DW] <= ext;
    end
  end
endmodule

// File: tb/tb_mem2_stage.sv
// tb_mem2_stage: table vectors, flush/backpressure sequences and randomized bundles vs a reference model.
module tb_mem2_stage;
  localparam int L = 2, D = 64;
  typedef struct {
    logic [L-1:0] lv;
    logic [L*32-1:0] pc;
    logic [L*5-1:0] dst;
    logic [L*D-1:0] alu;
    logic [L*2-1:0] rw;
    logic [L*2-1:0] ms;
    logic [L-1:0] sx;
  } bundle_t;
  typedef struct {
    logic [L*D-1:0] res;
    logic [L-1:0] exc;
    logic [L*5-1:0] code;
    bit waits;
  } exp_t;
  typedef struct {
    string nm;
    bundle_t b;
    logic [D-1:0] data;
    int dly;
    exp_t e;
  } vec_t;

  logic clk = 1'b0, reset = 1'b1;
  int checks = 0, errors = 0;
  mem2_stage_if #(.LANES(L), .DW(D)) bus ();
  mem2_stage #(.LANES(L), .DW(D)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // reference: memory lane, alignment and extraction from plain integer arithmetic
  function automatic exp_t model(input bundle_t b, input logic [D-1:0] data);
    exp_t e;
    int m = -1;
    e.res = b.alu;
    e.exc = '0;
    e.code = '0;
    e.waits = 0;
    for (int i = 0; i < L; i++)
      if (m < 0 && b.lv[i] && b.rw[2*i +: 2] != 2'b00) m = i;
    if (m >= 0) begin
      longint unsigned addr = b.alu[m*D +: D];
      longint unsigned bytes = 64'd1 << b.ms[2*m +: 2];
      bit ld = b.rw[2*m +: 2] == 2'b01;
      bit bad = 0;
`ifdef MEM2_MISALIGN_EXC_EN
      bad = (addr % bytes) != 0;
`endif
      if (bad) begin
        e.exc[m] = 1'b1;
        e.code[5*m +: 5] = ld ? 5'd4 : 5'd5;
      end else begin
        e.waits = 1;
        if (ld) begin
          longint unsigned v = data >> (8 * (addr % 8));
          int bits = 8 * int'(bytes);
          if (bits < 64) begin
            v = v % (64'd1 << bits);
            if (b.sx[m] && v >= (64'd1 << (bits - 1))) v = v - (64'd1 << bits);
          end
          e.res[m*D +: D] = v;
        end
      end
    end
    return e;
  endfunction

  function automatic bundle_t bun(input logic [1:0] lv, input logic [3:0] rw, input logic [3:0] ms,
                                  input logic [1:0] sx, input logic [63:0] a0, input logic [63:0] a1);
    bundle_t b;
    b.lv = lv;
    b.rw = rw;
    b.ms = ms;
    b.sx = sx;
    b.alu = {a1, a0};
    b.pc = {$urandom, $urandom};
    b.dst = 10'($urandom);
    return b;
  endfunction

  function automatic exp_t ex(input logic [63:0] r0, input logic [63:0] r1, input logic [1:0] exc,
                              input logic [9:0] code, input bit w);
    exp_t e;
    e.res = {r1, r0};
    e.exc = exc;
    e.code = code;
    e.waits = w;
    return e;
  endfunction

  task automatic drive(input bundle_t b);
    bus.in_lane_valid = b.lv;
    bus.in_pc = b.pc;
    bus.in_dst = b.dst;
    bus.in_alu_out = b.alu;
    bus.in_memrw = b.rw;
    bus.in_msize = b.ms;
    bus.in_memsext = b.sx;
  endtask

  task automatic check_out(input string nm, input bundle_t b, input exp_t e);
    chk({nm, " out_valid"}, bus.out_valid, 1);
    chk({nm, " lane_valid"}, bus.out_lane_valid, b.lv);
    chk({nm, " pc"}, bus.out_pc, b.pc);
    chk({nm, " dst"}, bus.out_dst, b.dst);
    chk({nm, " result"}, bus.out_result, e.res);
    chk({nm, " exc"}, bus.out_exc, e.exc);
    chk({nm, " exc_code"}, bus.out_exc_code, e.code);
  endtask

  // entered just after a rising edge with the stage idle; leaves it idle the same way
  task automatic run_txn(input string nm, input bundle_t b, input logic [D-1:0] data, input int dly,
                         input int hold, input exp_t e);
    int n = 0;
    drive(b);
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " accept"}, bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.out_ready = (hold == 0);
    if (e.waits) begin
      for (int k = 0; k < dly; k++) begin
        @(negedge clk);
        chk({nm, " wait out_valid"}, bus.out_valid, 0);
        @(posedge clk);
        #1;
      end
      bus.dresp_data_ok = 1'b1;
      bus.dresp_data = data;
      @(negedge clk);
      chk({nm, " wait in_ready"}, bus.in_ready, 0);
      chk({nm, " resp out_valid"}, bus.out_valid, 0);
      @(posedge clk);
      #1;
      bus.dresp_data_ok = 1'b0;
      bus.dresp_data = {$urandom, $urandom};
    end
    @(negedge clk);
    check_out(nm, b, e);
    for (int k = 1; k <= hold; k++) begin
      @(posedge clk);
      #1;
      if (k == hold) bus.out_ready = 1'b1;
      @(negedge clk);
      chk({nm, " hold in_ready"}, bus.in_ready, k == hold);
      check_out({nm, " held"}, b, e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic accept_one(input bundle_t b);
    drive(b);
    bus.in_valid = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    vec_t vt[10];
    bundle_t q[4];
    bundle_t b, b2;
    logic [D-1:0] d;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    drive(bun(0, 0, 0, 0, 0, 0));
    bus.dresp_data_ok = 1'b0;
    bus.dresp_data = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset out_valid", bus.out_valid, 0);
    chk("reset in_ready", bus.in_ready, 1);
    chk("reset out_result", bus.out_result, 0);
    chk("reset out_pc", bus.out_pc, 0);
    chk("reset out_lane_valid", bus.out_lane_valid, 0);
    chk("reset out_exc", bus.out_exc, 0);
    @(posedge clk);
    #1;

    vt[0] = '{"nomem", bun(2'b11, 4'b0000, 4'b0000, 2'b00, 64'h10, 64'h20), 64'h0, 0,
              ex(64'h10, 64'h20, 2'b00, 10'd0, 0)};
    vt[1] = '{"lb_sext", bun(2'b11, 4'b0100, 4'b0000, 2'b10, 64'h55, 64'h1003), 64'h0000_0000_80FF_0000, 2,
              ex(64'h55, 64'hFFFF_FFFF_FFFF_FF80, 2'b00, 10'd0, 1)};
    vt[2] = '{"lhu", bun(2'b01, 4'b0001, 4'b0001, 2'b00, 64'h2006, 64'h77), 64'hBEEF_0000_0000_0000, 1,
              ex(64'hBEEF, 64'h77, 2'b00, 10'd0, 1)};
`ifdef MEM2_MISALIGN_EXC_EN
    vt[3] = '{"lw_mis", bun(2'b01, 4'b0001, 4'b0010, 2'b01, 64'h3002, 64'h0), 64'h1122_3344_5566_7788, 0,
              ex(64'h3002, 64'h0, 2'b01, 10'd4, 0)};
    vt[5] = '{"sh_mis", bun(2'b01, 4'b0010, 4'b0001, 2'b00, 64'h5001, 64'h0), 64'h0, 0,
              ex(64'h5001, 64'h0, 2'b01, 10'd5, 0)};
`else
    vt[3] = '{"lw_off2", bun(2'b01, 4'b0001, 4'b0010, 2'b01, 64'h3002, 64'h0), 64'h1122_3344_5566_7788, 0,
              ex(64'h3344_5566, 64'h0, 2'b00, 10'd0, 1)};
    vt[5] = '{"sh_off1", bun(2'b01, 4'b0010, 4'b0001, 2'b00, 64'h5001, 64'h0), 64'h0, 1,
              ex(64'h5001, 64'h0, 2'b00, 10'd0, 1)};
`endif
    vt[4] = '{"sw", bun(2'b11, 4'b1000, 4'b1000, 2'b00, 64'h9, 64'h4008), 64'hDEAD_BEEF_DEAD_BEEF, 3,
              ex(64'h9, 64'h4008, 2'b00, 10'd0, 1)};
    vt[6] = '{"two_mem", bun(2'b11, 4'b0101, 4'b0011, 2'b11, 64'h6008, 64'h7001), 64'hCAFE_F00D_1234_5678, 1,
              ex(64'hCAFE_F00D_1234_5678, 64'h7001, 2'b00, 10'd0, 1)};
    vt[7] = '{"lane0_inv", bun(2'b10, 4'b0101, 4'b0100, 2'b10, 64'h1, 64'h8002), 64'h0000_0000_8001_0000, 0,
              ex(64'h1, 64'hFFFF_FFFF_FFFF_8001, 2'b00, 10'd0, 1)};
    vt[8] = '{"lbu_top", bun(2'b11, 4'b0001, 4'b0000, 2'b00, 64'h9007, 64'h33), 64'hF000_0000_0000_0000, 2,
              ex(64'hF0, 64'h33, 2'b00, 10'd0, 1)};
    vt[9] = '{"lw_sext", bun(2'b11, 4'b0100, 4'b1000, 2'b10, 64'h44, 64'hA004), 64'h89AB_CDEF_0000_0000, 1,
              ex(64'h44, 64'hFFFF_FFFF_89AB_CDEF, 2'b00, 10'd0, 1)};
    for (int i = 0; i < 10; i++) run_txn(vt[i].nm, vt[i].b, vt[i].data, vt[i].dly, 0, vt[i].e);

    // back-to-back non-memory bundles
    for (int k = 0; k < 4; k++) q[k] = bun(2'b11, 4'b0000, 4'b0000, 2'b00, 64'(k * 16 + 1), 64'(k * 16 + 2));
    drive(q[0]);
    bus.in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("stream in_ready", bus.in_ready, 1);
      if (k > 0) chk("stream result", bus.out_result, q[k-1].alu);
      @(posedge clk);
      #1;
      if (k < 3) drive(q[k+1]);
      else bus.in_valid = 1'b0;
    end
    @(negedge clk);
    chk("stream last", bus.out_result, q[3].alu);
    @(posedge clk);
    #1;

    // backpressure with ignored responses while full, then accept on release
    b = bun(2'b11, 4'b0000, 4'b0000, 2'b00, 64'hAAA1, 64'hAAA2);
    b2 = bun(2'b01, 4'b0000, 4'b0000, 2'b00, 64'hBBB1, 64'hBBB2);
    accept_one(b);
    bus.out_ready = 1'b0;
    drive(b2);
    bus.in_valid = 1'b1;
    bus.dresp_data_ok = 1'b1;
    bus.dresp_data = {$urandom, $urandom};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp out_valid", bus.out_valid, 1);
      chk("bp result", bus.out_result, b.alu);
      chk("bp in_ready", bus.in_ready, 0);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    bus.dresp_data_ok = 1'b0;
    @(negedge clk);
    chk("bp release in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("bp next valid", bus.out_valid, 1);
    chk("bp next result", bus.out_result, b2.alu);
    chk("bp next lane_valid", bus.out_lane_valid, b2.lv);
    @(posedge clk);
    #1;

    // flush in WAIT: the late response belongs to the flushed bundle
    accept_one(bun(2'b01, 4'b0001, 4'b0011, 2'b00, 64'h10, 64'h0));
    @(negedge clk);
    chk("fw wait valid", bus.out_valid, 0);
    @(posedge clk);
    #1 bus.flush = 1'b1;
    @(negedge clk);
    chk("fw flush in_ready", bus.in_ready, 0);
    @(posedge clk);
    #1 bus.flush = 1'b0;
    b2 = bun(2'b01, 4'b0001, 4'b0011, 2'b00, 64'h18, 64'h0);
    drive(b2);
    bus.in_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("drain in_ready", bus.in_ready, 0);
      chk("drain out_valid", bus.out_valid, 0);
      @(posedge clk);
      #1;
    end
    bus.dresp_data_ok = 1'b1;
    bus.dresp_data = 64'h1111_1111_1111_1111;
    @(negedge clk);
    chk("drain resp in_ready", bus.in_ready, 0);
    chk("drain resp out_valid", bus.out_valid, 0);
    @(posedge clk);
    #1 bus.dresp_data_ok = 1'b0;
    d = 64'h2222_3333_4444_5555;
    run_txn("after_drain", b2, d, 1, 0, model(b2, d));

    // flush together with the response: straight back to idle
    accept_one(bun(2'b10, 4'b0100, 4'b1100, 2'b00, 64'h0, 64'h20));
    bus.flush = 1'b1;
    bus.dresp_data_ok = 1'b1;
    bus.dresp_data = 64'h3333_3333_3333_3333;
    @(negedge clk);
    chk("fco out_valid", bus.out_valid, 0);
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    bus.dresp_data_ok = 1'b0;
    @(negedge clk);
    chk("fco idle out_valid", bus.out_valid, 0);
    chk("fco idle in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    b = bun(2'b01, 4'b0001, 4'b0010, 2'b01, 64'h40, 64'h0);
    d = 64'h0000_0000_FFFF_0000;
    run_txn("after_fco", b, d, 0, 0, model(b, d));

    // flush while full discards the held bundle
    accept_one(bun(2'b11, 4'b0000, 4'b0000, 2'b00, 64'h5, 64'h6));
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("ff out_valid", bus.out_valid, 1);
    @(posedge clk);
    #1 bus.flush = 1'b1;
    @(negedge clk);
    chk("ff flush in_ready", bus.in_ready, 0);
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("ff out_valid after", bus.out_valid, 0);
    chk("ff in_ready after", bus.in_ready, 1);
    @(posedge clk);
    #1;

    // reset during WAIT needs no drain
    accept_one(bun(2'b01, 4'b0001, 4'b0011, 2'b00, 64'h80, 64'h0));
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rw out_valid", bus.out_valid, 0);
    chk("rw in_ready", bus.in_ready, 1);
    chk("rw out_result", bus.out_result, 0);
    @(posedge clk);
    #1;

    for (int r = 0; r < 80; r++) begin
      b.lv = 2'($urandom);
      b.pc = {$urandom, $urandom};
      b.dst = 10'($urandom);
      b.sx = 2'($urandom);
      b.ms = 4'($urandom);
      for (int i = 0; i < L; i++) begin
        b.rw[2*i +: 2] = 2'($urandom_range(0, 2));
        b.alu[i*D +: D] = {$urandom, $urandom};
        if ($urandom_range(0, 1) == 0) b.alu[i*D +: 3] = 3'b000;
      end
      d = {$urandom, $urandom};
      run_txn("random", b, d, $urandom_range(0, 3), $urandom_range(0, 2), model(b, d));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
